// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM encoding, counter width and request legality for the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering; off/funct3/data in, mem_be, lane-shifted wdata and extended rdata out
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);
    logic [31:0] sh;
    always_comb begin
        sh        = rdata >> {off, 3'b000};
        be        = funct3[1:0] == 2'b00 ? 4'b0001 << off :
                    funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata_sh  = wdata << {off, 3'b000};
        rdata_ext = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                    funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                    funct3 == F3_BU ? {24'h0, sh[7:0]} :
                    funct3 == F3_HU ? {16'h0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage driving a req/ack word memory with lane steering and timeout
// Ports: CLK/RST (sync active-high); req_* one-cycle request from control; busy/done/err/rdata status;
//        mem_req/mem_we/mem_addr/mem_be/mem_wdata to memory, mem_ack/mem_rdata from memory.
// Option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses illegal instead of force-aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    state_t           state;
    logic             trap;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size;
    logic [1:0]       eff_off;
    logic             mis;
    logic             illegal;
    logic [1:0]       al_off;
    logic [2:0]       al_f3;
    logic [3:0]       be;
    logic [31:0]      wd_sh;
    logic [31:0]      rd_ext;

    assign size = req_funct3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis     = (size == 2'b01 && req_addr[0]) || (size == 2'b10 && req_addr[1:0] != 2'b00);
    assign eff_off = req_addr[1:0];
`else
    assign mis     = 1'b0;
    assign eff_off = size == 2'b10 ? 2'b00 : size == 2'b01 ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
    assign illegal = !f3_legal(req_we, req_funct3) || mis;
    assign busy    = state != IDLE;

    // One aligner serves both directions: request fields while idle (store lanes, byte enables),
    // latched fields while accessing (load extraction).
    assign al_off = state == IDLE ? eff_off : off_q;
    assign al_f3  = state == IDLE ? req_funct3 : f3_q;

    lsu_lane_align u_align (
        .off      (al_off),
        .funct3   (al_f3),
        .wdata    (req_wdata),
        .rdata    (mem_rdata),
        .be       (be),
        .wdata_sh (wd_sh),
        .rdata_ext(rd_ext)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            trap      <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            cnt       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    // Illegal requests still spend one cycle in ACCESS (without mem_req) so that
                    // done lands on the same cycle as the fastest legal access.
                    state     <= ACCESS;
                    trap      <= illegal;
                    we_q      <= req_we;
                    f3_q      <= req_funct3;
                    off_q     <= eff_off;
                    cnt       <= '0;
                    mem_req   <= !illegal;
                    mem_we    <= req_we && !illegal;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_be    <= illegal ? 4'h0 : be;
                    mem_wdata <= wd_sh;
                end
                ACCESS: begin
                    if (trap || mem_ack || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state   <= FINISH;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Any error returns zero data; a completed store leaves rdata untouched.
                    if (trap || !mem_ack) begin
                        err   <= trap || cnt == CNT_W'(TIMEOUT_CYC - 1);
                        if (trap || cnt == CNT_W'(TIMEOUT_CYC - 1))
                            rdata <= 32'h0;
                    end else if (!we_q) begin
                        rdata <= rd_ext;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit lanes, extension, latency, errors, timeout and reset
module tb_load_store_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        t_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        t_busy, t_done, t_err, t_mem_req, t_mem_we;
    logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    load_store_unit dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT_CYC(4)) dut_to (
        .CLK(CLK), .RST(RST), .req_valid(t_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(t_busy), .done(t_done), .err(t_err),
        .rdata(t_rdata), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rdata", rdata, e.rd);
                check("sb_err", 32'(err), 32'(e.err));
                check("sb_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // ack_cyc = 0 means the request must never reach memory (illegal); ign_at pulses a stray req_valid.
    task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_cyc, input int ign_at,
                           input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                           input logic [31:0] e_rd, input logic e_err);
        exp_t e;
        e.rd  = e_rd;
        e.err = e_err;
        e.cyc = cyc + (ack_cyc > 0 ? ack_cyc : 1) + 1;
        sb_q.push_back(e);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; mem_rdata = rd;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'(1));
        if (ack_cyc > 0) begin
            for (int j = 1; j <= ack_cyc; j++) begin
                check({name, "_mem_req"}, 32'(mem_req), 32'(1));
                check({name, "_mem_addr"}, mem_addr, e_addr);
                if (j == 1) begin
                    check({name, "_mem_be"}, 32'(mem_be), 32'(e_be));
                    check({name, "_mem_wdata"}, mem_wdata, e_wd);
                    check({name, "_mem_we"}, 32'(mem_we), 32'(we));
                end
                if (j == ign_at) begin
                    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h300; req_funct3 = 3'b010;
                end
                mem_ack = (j == ack_cyc);
                tick;
                req_valid = 1'b0;
                mem_ack = 1'b0;
            end
        end else begin
            check({name, "_no_mem_req"}, 32'(mem_req), 32'(0));
            tick;
        end
        check({name, "_req_released"}, 32'(mem_req), 32'(0));
        tick;
        check({name, "_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        repeat (2) tick;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'(0));
        check("rst_mem_wdata", mem_wdata, 32'h0);
        RST = 1'b0;
        tick;
        run_txn("sb",  1'b1, 3'b000, 32'h103, 32'hAB, 32'h0, 1, 0, 32'h100, 4'b1000, 32'hAB00_0000, 32'h0, 1'b0);
        run_txn("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
        run_txn("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 1, 0, 32'h100, 4'b1100, 32'h0, 32'h0000_8001, 1'b0);
        run_txn("lb",  1'b0, 3'b000, 32'h101, 32'h0, 32'h8001_1234, 1, 0, 32'h100, 4'b0010, 32'h0, 32'h0000_0012, 1'b0);
        run_txn("lw",  1'b0, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 6, 3, 32'h200, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_txn("sh",  1'b1, 3'b001, 32'h206, 32'hBEEF, 32'h0, 2, 0, 32'h204, 4'b1100, 32'hBEEF_0000, 32'hDEAD_BEEF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
`else
        run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 1, 0, 32'h100, 4'b1111, 32'h0, 32'h1122_3344, 1'b0);
`endif
        run_txn("ld_bad", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        run_txn("st_bad", 1'b1, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        // timeout on the TIMEOUT_CYC=4 instance, memory never acks
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; mem_rdata = 32'h5555_AAAA;
        t_valid = 1'b1;
        tick;
        t_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            check("to_mem_req", 32'(t_mem_req), 32'(1));
            check("to_mem_addr", t_mem_addr, 32'h40);
            check("to_no_done", 32'(t_done), 32'(0));
            tick;
        end
        check("to_done", 32'(t_done), 32'(1));
        check("to_err", 32'(t_err), 32'(1));
        check("to_rdata", t_rdata, 32'h0);
        check("to_mem_req_low", 32'(t_mem_req), 32'(0));
        tick;
        check("to_busy_low", 32'(t_busy), 32'(0));
        check("to_done_pulse", 32'(t_done), 32'(0));
        // reset in the middle of a pending store
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        check("rstmid_mem_req", 32'(mem_req), 32'(1));
        tick;
        tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        check("rstmid_mem_req_low", 32'(mem_req), 32'(0));
        check("rstmid_busy", 32'(busy), 32'(0));
        check("rstmid_done", 32'(done), 32'(0));
        repeat (3) tick;
        run_txn("lw_after_rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 2, 0, 32'h20, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        repeat (2) tick;
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
